// File: rtl/ro_burst_responder.sv
// Read-only burst responder: accepts one aligned line-fill request at a time,
// splits it into pipelined single-word backing reads, returns words in order.
module ro_burst_responder #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_W          = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request,
  input  logic [ADDR_W-1:0] addr,
  input  logic [4:0]        rlen,
  output logic              ack,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              bmem_req,
  output logic [ADDR_W-1:0] bmem_addr,
  input  logic              bmem_gnt,
  input  logic              bmem_rvalid,
  input  logic [31:0]       bmem_rdata,
  output logic              busy
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [4:0]        len_q;
  logic [4:0]        issue_cnt_q;
  logic [4:0]        ret_cnt_q;
  logic [OW-1:0]     out_q;
  logic [OW-1:0]     out_d;
  logic              ack_q;
  logic              rvalid_q;
  logic [31:0]       rdata_q;

  logic grant;
  logic ret;
  logic ret_last;
  logic issue_last;

  // Slot decision uses only the registered count; same-cycle returns don't help.
  assign bmem_req   = (state_q == ISSUE) && (out_q < MAX_OUT);
  assign bmem_addr  = base_q + ADDR_W'(issue_cnt_q);
  assign grant      = bmem_req && bmem_gnt;
  assign ret        = bmem_rvalid && (out_q != '0);
  assign ret_last   = ret && (ret_cnt_q == len_q);
  assign issue_last = grant && (issue_cnt_q == len_q);

  assign ack    = ack_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign busy   = (state_q != IDLE);

  always_comb begin
    out_d = out_q;
    if (grant && !ret) begin
      out_d = out_q + 1'b1;
    end else if (!grant && ret) begin
      out_d = out_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      out_q       <= '0;
      ack_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      ack_q    <= 1'b0;
      rvalid_q <= ret;
      out_q    <= out_d;
      if (ret) begin
        rdata_q   <= bmem_rdata;
        ret_cnt_q <= ret_cnt_q + 5'd1;
      end
      if (grant) begin
        issue_cnt_q <= issue_cnt_q + 5'd1;
      end
      unique case (state_q)
        IDLE: begin
          if (request) begin
            ack_q       <= 1'b1;
            state_q     <= ISSUE;
            base_q      <= addr & ~ADDR_W'(rlen);
            len_q       <= rlen;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
          end
        end
        ISSUE: begin
          if (ret_last) begin
            state_q <= IDLE;
          end else if (issue_last) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (ret_last) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ro_burst_responder.md
Name: ro_burst_responder

Overview:
- Responder end of the read-only burst memory interface driven by the instruction cache.
- Accepts one line-fill request (word address plus rlen) at a time and acknowledges it with a one-cycle pulse.
- Breaks the burst into single-word reads on a pipelined backing-memory port.
- Returns the rlen+1 words in order, from the line base upward, with no backpressure toward the master.

Parameters:
- MAX_OUTSTANDING, 4, maximum backing reads issued but not yet returned (1..16).
- ADDR_W, 30, word-address width on both interfaces.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- request  in  1  master burst request; held until ack
- addr  in  ADDR_W  word address of the requested word
- rlen  in  5  burst length minus one; rlen+1 is a power of two
- ack  out  1  one-cycle accept pulse
- rvalid  out  1  return word valid
- rdata  out  32  return word
- bmem_req  out  1  backing read request
- bmem_addr  out  ADDR_W  backing word address
- bmem_gnt  in  1  backing accepts the read this cycle
- bmem_rvalid  in  1  backing read data valid, in issue order
- bmem_rdata  in  32  backing read data
- busy  out  1  burst in progress (state != IDLE)

Behaviour:
- Reset (rst low, asynchronous) forces state IDLE and clears all counters.
- Outputs under reset: ack=0, rvalid=0, rdata=0, bmem_req=0, busy=0.
- Reset mid-burst abandons the burst. Backing returns arriving after reset are treated as spurious and dropped.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - If request=1, on the next edge: ack<=1 for exactly one cycle, state<=ISSUE.
  - Latch base = addr & ~ZEXT(rlen), len_r = rlen, issue_cnt=0, ret_cnt=0.
  - ack is registered. The master sees it one cycle after the accepting edge and must drop request.
  - request held high in the ack cycle is ignored, because state is no longer IDLE.
- ISSUE:
  - bmem_req = (outstanding < MAX_OUTSTANDING).
  - bmem_addr = base + issue_cnt, using ADDR_W-bit arithmetic.
  - bmem_req is active from the ack cycle onward.
  - On bmem_req & bmem_gnt: issue_cnt++ and outstanding++.
  - After the grant with issue_cnt == len_r: state<=DRAIN.
  - bmem_req does not wait for bmem_gnt. With gnt low, req and addr stay stable.
- DRAIN: bmem_req=0; waits for the remaining returns.
- Outstanding counter:
  - Width is clog2(MAX_OUTSTANDING)+1.
  - +1 on grant, -1 on an accepted return. Both in one cycle leaves it unchanged.
  - A return arriving in the same cycle does not free a slot for that cycle's request decision.
- Return path:
  - bmem_rvalid is accepted only when outstanding > 0 (a grant in the same cycle does not count).
  - Otherwise bmem_rvalid is dropped silently.
  - An accepted return registers rvalid<=1 and rdata<=bmem_rdata, so latency is one cycle.
  - rdata holds its last value when rvalid=0.
  - Each accepted return increments ret_cnt.
- Completion:
  - The accepted return with ret_cnt == len_r is the last word.
  - On that edge state<=IDLE, from either ISSUE or DRAIN.
  - The final rvalid appears in the first IDLE cycle.
  - A new request may be sampled in that same IDLE cycle, giving ack 1 cycle after the last rvalid.
- Word order: strictly base, base+1, …, base+len_r. There is no critical-word-first reordering.
- rlen=0: a single read at addr, where base=addr.
- Address wrap: base+issue_cnt wraps modulo 2^ADDR_W.
- Invariants:
  - ack only while request=1.
  - rvalid count per burst equals len_r+1 exactly.
  - outstanding never exceeds MAX_OUTSTANDING.

Test Plan:
- Zero-latency backing (gnt=1, rvalid one cycle after grant), request addr=0x1003, rlen=7:
  - ack pulses one cycle.
  - bmem_addr runs 0x1000..0x1007 on consecutive cycles.
  - rvalid delivers 8 words in order.
  - busy drops and state is IDLE after the 8th word.
- MAX_OUTSTANDING=4, backing latency 10 cycles, rlen=7:
  - bmem_req deasserts after 4 grants.
  - Each return frees one slot.
  - All 8 words arrive in order, and outstanding never exceeds 4.
- Random bmem_gnt stalls (≈50%), rlen=3, addr=0x2002:
  - bmem_req/bmem_addr stay stable while gnt=0.
  - Addresses are 0x2000..0x2003, each issued exactly once.
- rlen=0 at addr=0x3FFFFFFF: single read at 0x3FFFFFFF, one rvalid, immediate IDLE.
- Back-to-back bursts: second request asserted during the first's final return → ack appears the cycle after the final rvalid; no interleaving of words.
- Reset asserted asynchronously mid-ISSUE, with 2 returns still in flight after release:
  - All outputs 0 immediately.
  - The late bmem_rvalid pulses are dropped (rvalid stays 0).
  - A subsequent request completes normally.
